// File: rtl/keypad_if.sv
// Keypad matrix signal bundle: row sense inputs, column drive and the
// debounced key report consumed by the date/month setting stage.
interface keypad_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       pressed;
    logic       key_valid;

    modport slave (
        input  row_n,
        output col_n,
        output key_code,
        output pressed,
        output key_valid
    );

    modport master (
        output row_n,
        input  col_n,
        input  key_code,
        input  pressed,
        input  key_valid
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates an active-low column strobe, debounces a press
// on the driven column and reports one pulse per accepted press.
module keypad_scan #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.slave  kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_N + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_N);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    col_n_q, col_n_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] match_q, match_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          pressed_q, pressed_d;
    logic          key_valid_q, key_valid_d;
    logic          sample_s;
    logic          row_high_s;
    logic [3:0]    col_next_s;

    function automatic logic [1:0] lowest_row(input logic [3:0] rn);
        logic [1:0] r;
        if (!rn[0]) begin
            r = 2'd0;
        end else if (!rn[1]) begin
            r = 2'd1;
        end else if (!rn[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] cn);
        logic [1:0] c;
        case (cn)
            4'b1110: c = 2'd0;
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            4'b0111: c = 2'd3;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

    assign sample_s   = (dwell_q == DWELL_LAST);
    assign row_high_s = kp.row_n[row_q];
    assign col_next_s = {col_n_q[2:0], col_n_q[3]};

    // Next-state and output decode for the scan/debounce FSM
    always_comb begin
        state_d     = state_q;
        dwell_d     = sample_s ? '0 : dwell_q + 1'b1;
        col_n_d     = col_n_q;
        row_d       = row_q;
        match_d     = match_q;
        rel_d       = rel_q;
        key_code_d  = key_code_q;
        pressed_d   = 1'b0;
        key_valid_d = key_valid_q;

        case (state_q)
            ST_SCAN: begin
                if (!sample_s) begin
                    state_d = ST_SCAN;
                end else if (kp.row_n == 4'hF) begin
                    col_n_d = col_next_s;
                end else if (DB_LAST == CNT_ONE) begin
                    // Single-sample debounce: the detection sample accepts.
                    row_d       = lowest_row(kp.row_n);
                    key_code_d  = {lowest_row(kp.row_n), col_index(col_n_q)};
                    pressed_d   = 1'b1;
                    key_valid_d = 1'b1;
                    match_d     = '0;
                    state_d     = ST_HELD;
                end else begin
                    row_d   = lowest_row(kp.row_n);
                    match_d = CNT_ONE;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!sample_s) begin
                    state_d = ST_DEBOUNCE;
                end else if (row_high_s) begin
                    match_d = '0;
                    col_n_d = col_next_s;
                    state_d = ST_SCAN;
                end else if ((match_q + CNT_ONE) == DB_LAST) begin
                    key_code_d  = {row_q, col_index(col_n_q)};
                    pressed_d   = 1'b1;
                    key_valid_d = 1'b1;
                    match_d     = '0;
                    state_d     = ST_HELD;
                end else begin
                    match_d = match_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!sample_s || !row_high_s) begin
                    state_d = ST_HELD;
                end else if (DB_LAST == CNT_ONE) begin
                    key_valid_d = 1'b0;
                    col_n_d     = col_next_s;
                    state_d     = ST_SCAN;
                end else begin
                    rel_d   = CNT_ONE;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!sample_s) begin
                    state_d = ST_RELEASE;
                end else if (!row_high_s) begin
                    rel_d   = '0;
                    state_d = ST_HELD;
                end else if ((rel_q + CNT_ONE) == DB_LAST) begin
                    rel_d       = '0;
                    key_valid_d = 1'b0;
                    col_n_d     = col_next_s;
                    state_d     = ST_SCAN;
                end else begin
                    rel_d = rel_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            dwell_q     <= '0;
            col_n_q     <= 4'b1110;
            row_q       <= 2'd0;
            match_q     <= '0;
            rel_q       <= '0;
            key_code_q  <= 4'd0;
            pressed_q   <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            col_n_q     <= col_n_d;
            row_q       <= row_d;
            match_q     <= match_d;
            rel_q       <= rel_d;
            key_code_q  <= key_code_d;
            pressed_q   <= pressed_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign kp.col_n     = col_n_q;
    assign kp.key_code  = key_code_q;
    assign kp.pressed   = pressed_q;
    assign kp.key_valid = key_valid_q;
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles each column is driven (dwell); legal range >= 2.
REQ-002 Parameter DEBOUNCE_N, default 4, consecutive matching samples needed to accept a press or a release; legal range >= 1.
REQ-003 clk  input  1  single system clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 row_n  input  4  keypad rows, active-low (externally pulled up); row_n[r]=0 means a key in row r is closed on the driven column.
REQ-006 col_n  output  4  column drive, active-low one-hot; exactly one bit is 0 at all times.
REQ-007 key_code  output  4  debounced key code = {row[1:0], col[1:0]}; the matrix is wired so that key A = 4'd10 and key B = 4'd11.
REQ-008 pressed  output  1  one-cycle pulse per accepted press; feeds the date/month setting stage's pressed input.
REQ-009 key_valid  output  1  high from the accepted press until the accepted release.

Function
REQ-010 Dwell counter: counts 0..SCAN_DIV-1 and wraps; the "sample cycle" is the cycle in which it equals SCAN_DIV-1; row_n is evaluated only in sample cycles.
REQ-011 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-012 SCAN: at each sample cycle, if row_n == 4'hF, advance the column to (col+1) mod 4 (col 3 -> col 0).
REQ-013 SCAN, sample cycle, row_n != 4'hF: latch candidate row = lowest index r with row_n[r]=0; hold the current column; set match count = 1; go to DEBOUNCE.
REQ-014 DEBOUNCE, sample cycle, same candidate row still low: increment match count. On reaching DEBOUNCE_N: load key_code, pulse pressed, set key_valid=1, go to HELD.
REQ-015 DEBOUNCE, sample cycle, candidate row high: clear match count, advance column, return to SCAN; no outputs change.
REQ-016 DEBOUNCE_N=1: the SCAN detection sample itself accepts the press; go directly to HELD.
REQ-017 pressed asserts in the cycle after the accepting sample cycle, for exactly 1 clk.
REQ-018 HELD: column stays frozen; no further pressed pulses however long the key is held. At a sample cycle with the held row high, set release count = 1 and go to RELEASE.
REQ-019 RELEASE, sample cycle: held row high -> increment release count; on reaching DEBOUNCE_N, clear key_valid, advance column, go to SCAN. Held row low -> return to HELD, clear release count.
REQ-020 key_code keeps the last accepted value after release and changes only on a new accepted press.
REQ-021 While in DEBOUNCE, HELD or RELEASE, other rows going low are ignored.
REQ-022 Counters: dwell counter width clog2(SCAN_DIV); match/release counters width clog2(DEBOUNCE_N+1); no counter overflows.

Reset
REQ-023 While rst=1 at a clk edge: state=SCAN, col_n=4'b1110, dwell/match/release counters=0, key_code=4'd0, pressed=0, key_valid=0.
REQ-024 Reset asserted in any state, including mid-DEBOUNCE or HELD, discards the candidate row; no pressed pulse is produced for that press.
REQ-025 After reset, a key still held is detected afresh through SCAN/DEBOUNCE and yields one pressed pulse.

Verification (SCAN_DIV=4, DEBOUNCE_N=3)
REQ-026 Clean press: row_n[2]=0 only while col_n=4'b1011 and held -> one pressed pulse, key_code=10, key_valid=1; pressed rises 1 clk after the 3rd sample on col 2.
REQ-027 Bounce: row low for 1 sample only -> no pressed, key_code unchanged, scan resumes at col 3 (col_n=4'b0111) on the next dwell.
REQ-028 Long hold of 100 dwells, then release -> exactly one pressed pulse; key_valid falls 1 clk after the 3rd consecutive high sample; key_code stays 10.
REQ-029 Two rows low on col 3 (rows 1 and 3) -> key_code=4'd7 (lowest row wins).
REQ-030 rst pulsed after 2 matching samples -> no pressed, col_n=4'b1110, key_code=0; with key still held, it is re-detected and gives one pulse.
REQ-031 Idle keypad (row_n=4'hF) -> col_n rotates 1110,1101,1011,0111,1110 every 4 clk; pressed stays 0.
